// File: rtl/kr580_uart_pkg.sv
// Shared definitions for the KR580 port-mapped UART: register offsets, STATUS/CTRL bit
// positions and the TX/RX state encodings.
package kr580_uart_pkg;

  localparam logic [7:0] OffData   = 8'd0;
  localparam logic [7:0] OffStatus = 8'd1;
  localparam logic [7:0] OffCtrl   = 8'd2;

  localparam int unsigned StRxRdy   = 0;
  localparam int unsigned StTxEmpty = 1;
  localparam int unsigned StTxFull  = 2;
  localparam int unsigned StTxBusy  = 3;
  localparam int unsigned StRxOvr   = 4;
  localparam int unsigned StTxOvf   = 5;
  localparam int unsigned StRxFerr  = 6;

  localparam int unsigned CtrlRxie = 0;
  localparam int unsigned CtrlTxie = 1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/kr580_uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter; depth 2**FIFO_AW, full/empty from an
// occupancy counter. Push while full and pop while empty are ignored.
module kr580_uart_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   CntOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and counter.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/kr580_port_uart.sv
// KR580 port-bus UART: registers at BASE_ADDR+0..2, buffered 8N1 TX, optional receiver
// enabled by defining KR580_UART_RX_EN (default build has no RX logic).
module kr580_port_uart
  import kr580_uart_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned CLK_DIV   = 217,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin_pa,
  input  logic [7:0] pin_po,
  input  logic       pin_pw,
  output logic [7:0] pin_pi,
  output logic       pin_intr,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

  logic [7:0] offset;
  logic       addr_hit, wr_stb, wr_data, wr_status, wr_ctrl;
  logic       pw_q;

  logic       fifo_pop, fifo_empty, fifo_full;
  logic [7:0] fifo_dout;

  tx_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       tx_busy, tx_empty;

  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] status;
  logic [7:0] pi_q, pi_d;
  logic       intr_q, intr_d;

  logic       rx_rdy, rx_ovr, rx_ferr;
  logic [7:0] rx_hold;

  // Offset arithmetic wraps, so a base near 8'hFF still decodes three ports.
  assign offset    = pin_pa - BASE_ADDR;
  assign addr_hit  = (offset < 8'd3);
  assign wr_stb    = pin_pw & ~pw_q & addr_hit;
  assign wr_data   = wr_stb & (offset == OffData);
  assign wr_status = wr_stb & (offset == OffStatus);
  assign wr_ctrl   = wr_stb & (offset == OffCtrl);

  kr580_uart_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .din_i   (pin_po),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign tx_busy  = (tx_state_q != TxIdle);
  assign tx_empty = fifo_empty & ~tx_busy;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_d       = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            tx_d       = 1'b0;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (wr_status && pin_po[StTxOvf]) tx_ovf_d = 1'b0;
    if (wr_data && fifo_full)         tx_ovf_d = 1'b1;
    ctrl_d = wr_ctrl ? pin_po[1:0] : ctrl_q;
  end

`ifdef KR580_UART_RX_EN
  localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        rx_rdy_q, rx_rdy_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic        rx_done, rx_bad;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == DivLast) begin
          rx_done    = rx_s2_q;
          rx_bad     = ~rx_s2_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Clears are applied first so a byte completing in the same cycle wins.
  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_rdy_d  = rx_rdy_q;
    rx_ovr_d  = rx_ovr_q;
    rx_ferr_d = rx_ferr_q;
    if (wr_status) begin
      if (pin_po[StRxRdy])  rx_rdy_d  = 1'b0;
      if (pin_po[StRxOvr])  rx_ovr_d  = 1'b0;
      if (pin_po[StRxFerr]) rx_ferr_d = 1'b0;
    end
    if (rx_done) begin
      rx_hold_d = rx_shift_q;
      rx_rdy_d  = 1'b1;
      if (rx_rdy_q) rx_ovr_d = 1'b1;
    end
    if (rx_bad) rx_ferr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_hold_q  <= '0;
      rx_rdy_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_hold_q  <= rx_hold_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_rdy  = rx_rdy_q;
  assign rx_ovr  = rx_ovr_q;
  assign rx_ferr = rx_ferr_q;
  assign rx_hold = rx_hold_q;
`else
  logic unused_rx;
  assign unused_rx = uart_rx;
  assign rx_rdy    = 1'b0;
  assign rx_ovr    = 1'b0;
  assign rx_ferr   = 1'b0;
  assign rx_hold   = 8'h00;
`endif

  always_comb begin
    status            = '0;
    status[StRxRdy]   = rx_rdy;
    status[StTxEmpty] = tx_empty;
    status[StTxFull]  = fifo_full;
    status[StTxBusy]  = tx_busy;
    status[StRxOvr]   = rx_ovr;
    status[StTxOvf]   = tx_ovf_q;
    status[StRxFerr]  = rx_ferr;

    pi_d = 8'h00;
    if (addr_hit) begin
      case (offset)
        OffData:   pi_d = rx_hold;
        OffStatus: pi_d = status;
        OffCtrl:   pi_d = {6'b0, ctrl_q};
        default:   pi_d = 8'h00;
      endcase
    end

    intr_d = (ctrl_q[CtrlRxie] & rx_rdy) | (ctrl_q[CtrlTxie] & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pw_q       <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_ovf_q   <= 1'b0;
      ctrl_q     <= '0;
      pi_q       <= '0;
      intr_q     <= 1'b0;
    end else begin
      pw_q       <= pin_pw;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_ovf_q   <= tx_ovf_d;
      ctrl_q     <= ctrl_d;
      pi_q       <= pi_d;
      intr_q     <= intr_d;
    end
  end

  assign pin_pi   = pi_q;
  assign pin_intr = intr_q;
  assign uart_tx  = tx_q;

endmodule

// File: tb/tb_kr580_port_uart.sv
// Self-checking bench for kr580_port_uart with CLK_DIV=4, FIFO_AW=4, BASE=F0: register
// vector table plus TX framing, FIFO overflow, RX (when built) and mid-frame reset sequences.
module tb_kr580_port_uart;

  localparam logic [7:0] Base = 8'hF0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pin_pa = 8'h00;
  logic [7:0] pin_po = 8'h00;
  logic       pin_pw = 1'b0;
  logic [7:0] pin_pi;
  logic       pin_intr;
  logic       uart_tx;
  logic       uart_rx = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kr580_port_uart #(
    .BASE_ADDR (8'hF0),
    .CLK_DIV   (4),
    .FIFO_AW   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pin_pa   (pin_pa),
    .pin_po   (pin_po),
    .pin_pw   (pin_pw),
    .pin_pi   (pin_pi),
    .pin_intr (pin_intr),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  typedef struct {
    logic       wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp_pi;
    logic       exp_intr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic port_write(input logic [7:0] addr, input logic [7:0] data);
    pin_pa = addr;
    pin_po = data;
    pin_pw = 1'b1;
    step();
    pin_pw = 1'b0;
    step();
  endtask

  task automatic port_read(input logic [7:0] addr, output logic [7:0] val);
    pin_pa = addr;
    step();
    step();
    val = pin_pi;
  endtask

  // Waits for a start bit, then records 40 per-clock samples of one frame.
  task automatic grab_frame(output logic [7:0] data, output logic shape_ok, output int gap);
    logic s [40];
    gap = 0;
    data = 8'h00;
    shape_ok = 1'b0;
    step();
    while (uart_tx !== 1'b0 && gap < 300) begin
      step();
      gap++;
    end
    if (gap >= 300) return;
    s[0] = uart_tx;
    for (int i = 1; i < 40; i++) begin
      step();
      s[i] = uart_tx;
    end
    shape_ok = (s[0] == 1'b0) && (s[36] == 1'b1);
    for (int b = 0; b < 10; b++)
      for (int j = 1; j < 4; j++)
        if (s[4*b+j] !== s[4*b]) shape_ok = 1'b0;
    for (int k = 0; k < 8; k++) data[k] = s[4*(k+1)];
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    uart_rx = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (4) step();
    end
    uart_rx = stop;
    repeat (4) step();
    uart_rx = 1'b1;
    repeat (8) step();
  endtask

  logic [7:0] rd, fdata;
  logic       fok;
  int         gap, lows;
  logic [7:0] frames [17];
  logic       oks [17];
  int         gaps [17];

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'hF1, 8'h02, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'hF2, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'hF2, 8'h03, 8'hF2, 8'h03, 1'b1};
    vecs[3]  = '{1'b1, 8'hF2, 8'hFC, 8'hF2, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'hF2, 8'h02, 8'hF2, 8'h02, 1'b1};
    vecs[5]  = '{1'b1, 8'hF2, 8'h00, 8'hF0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'hF3, 8'h03, 8'hF2, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 8'hEF, 8'h03, 8'hF2, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'hF3, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 8'hF1, 8'hFF, 8'hF1, 8'h02, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'hEF, 8'h00, 1'b0};

    repeat (3) step();
    check("reset_pi", pin_pi, 8'h00);
    check("reset_tx", {7'b0, uart_tx}, 8'h01);
    check("reset_intr", {7'b0, pin_intr}, 8'h00);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) port_write(vecs[i].waddr, vecs[i].wdata);
      port_read(vecs[i].raddr, rd);
      check($sformatf("vec%0d_pi", i), rd, vecs[i].exp_pi);
      check($sformatf("vec%0d_intr", i), {7'b0, pin_intr}, {7'b0, vecs[i].exp_intr});
    end

    // Long write strobe must produce exactly one frame.
    pin_pa = Base;
    pin_po = 8'hA5;
    pin_pw = 1'b1;
    fork
      begin
        repeat (4) step();
        pin_pw = 1'b0;
      end
      grab_frame(fdata, fok, gap);
    join
    check("a5_data", fdata, 8'hA5);
    check("a5_shape", {7'b0, fok}, 8'h01);
    count_lows(40, lows);
    check("a5_single_frame", 8'(lows), 8'h00);
    port_read(Base + 8'd1, rd);
    check("a5_status_after", rd, 8'h02);

    // One byte in flight, then 17 more: 16 fit the FIFO, the last is dropped.
    fork
      begin
        port_write(Base, 8'hE0);
        for (int i = 0; i < 17; i++) port_write(Base, 8'h10 + 8'(i));
        port_read(Base + 8'd1, rd);
        check("ovf_status_full", rd, 8'h2C);
      end
      begin
        for (int i = 0; i < 17; i++) grab_frame(frames[i], oks[i], gaps[i]);
      end
    join
    check("ovf_frame0", frames[0], 8'hE0);
    check("ovf_shape0", {7'b0, oks[0]}, 8'h01);
    for (int i = 1; i < 17; i++) begin
      check($sformatf("ovf_frame%0d", i), frames[i], 8'h10 + 8'(i - 1));
      check($sformatf("ovf_shape%0d", i), {7'b0, oks[i]}, 8'h01);
      check($sformatf("ovf_gap%0d", i), 8'(gaps[i]), 8'h00);
    end
    count_lows(60, lows);
    check("ovf_no_extra_frame", 8'(lows), 8'h00);
    port_read(Base + 8'd1, rd);
    check("ovf_status_idle", rd, 8'h22);
    port_write(Base + 8'd1, 8'h20);
    port_read(Base + 8'd1, rd);
    check("ovf_cleared", rd, 8'h02);

`ifdef KR580_UART_RX_EN
    port_write(Base + 8'd2, 8'h01);
    send_frame(8'h3C, 1'b1);
    port_read(Base + 8'd1, rd);
    check("rx_status_rdy", rd, 8'h03);
    check("rx_intr", {7'b0, pin_intr}, 8'h01);
    port_read(Base, rd);
    check("rx_data_3c", rd, 8'h3C);
    send_frame(8'h7E, 1'b1);
    port_read(Base, rd);
    check("rx_data_7e", rd, 8'h7E);
    port_read(Base + 8'd1, rd);
    check("rx_status_ovr", rd, 8'h13);
    port_write(Base + 8'd1, 8'h11);
    port_read(Base + 8'd1, rd);
    check("rx_status_cleared", rd, 8'h02);
    check("rx_intr_cleared", {7'b0, pin_intr}, 8'h00);
    send_frame(8'h55, 1'b0);
    port_read(Base + 8'd1, rd);
    check("rx_ferr", rd, 8'h42);
    port_read(Base, rd);
    check("rx_ferr_hold", rd, 8'h7E);
    port_write(Base + 8'd1, 8'h40);
    uart_rx = 1'b0;
    step();
    uart_rx = 1'b1;
    repeat (60) step();
    port_read(Base + 8'd1, rd);
    check("rx_glitch_status", rd, 8'h02);
    port_read(Base, rd);
    check("rx_glitch_hold", rd, 8'h7E);
`else
    port_write(Base + 8'd2, 8'h01);
    send_frame(8'h3C, 1'b1);
    port_read(Base + 8'd1, rd);
    check("norx_status", rd, 8'h02);
    check("norx_intr", {7'b0, pin_intr}, 8'h00);
    port_read(Base, rd);
    check("norx_data", rd, 8'h00);
    port_read(Base + 8'd2, rd);
    check("norx_ctrl_stored", rd, 8'h01);
`endif

    // Reset in the middle of a low data bit, with more bytes still queued.
    port_write(Base + 8'd2, 8'h02);
    port_write(Base, 8'h00);
    port_write(Base, 8'h01);
    port_write(Base, 8'h02);
    gap = 0;
    while (uart_tx !== 1'b0 && gap < 200) begin
      step();
      gap++;
    end
    check("rst_frame_started", {7'b0, uart_tx}, 8'h00);
    repeat (6) step();
    reset = 1'b1;
    step();
    check("rst_tx_high", {7'b0, uart_tx}, 8'h01);
    check("rst_intr", {7'b0, pin_intr}, 8'h00);
    check("rst_pi", pin_pi, 8'h00);
    reset = 1'b0;
    port_read(Base + 8'd1, rd);
    check("rst_status", rd, 8'h02);
    port_read(Base + 8'd2, rd);
    check("rst_ctrl", rd, 8'h00);
    count_lows(100, lows);
    check("rst_fifo_flushed", 8'(lows), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kr580_port_uart.md
# kr580_port_uart

Port-mapped UART peripheral answering the KR580 core's I/O port bus (`pin_pa`/`pin_po`/`pin_pw` in, `pin_pi` out), with interrupt request on `pin_intr`. Sits beside the memory array on the system clock; the CPU runs on a divided clock, so all port strobes are edge-detected here. Provides a buffered 8N1 transmitter with a TX FIFO and a single-byte receive holding register.

## Interface
- `BASE_ADDR`, 8'hF0: port address of register 0; registers at BASE+0..BASE+2.
- `CLK_DIV`, 217: clk cycles per bit (25 MHz / 115200); legal range 4..65535.
- `FIFO_AW`, 4: TX FIFO address width; depth = 2**FIFO_AW.

- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `pin_pa` in 8: port address from CPU.
- `pin_po` in 8: port write data from CPU.
- `pin_pw` in 1: port write strobe; may stay high for several `clk` cycles.
- `pin_pi` out 8: port read data to CPU; 8'h00 when not addressed, so several peripherals can be ORed.
- `pin_intr` out 1: interrupt request, level, registered.
- `uart_tx` out 1: serial out, idle high.
- `uart_rx` in 1: serial in, asynchronous.

## Operation
- Write accepted in the cycle where `pin_pw`=1 and its registered copy `pw_q`=0 and `pin_pa` is in BASE..BASE+2; exactly one action per strobe regardless of its length.
- BASE+0 DATA: write pushes `pin_po` into the TX FIFO; if full, byte dropped and `tx_ovf` set (full checked on current count, even if a pop happens the same cycle). Read returns the RX holding register.
- BASE+1 STATUS read: bit0 `rx_rdy`, bit1 `tx_empty` (FIFO empty and shifter idle), bit2 `tx_full`, bit3 `tx_busy`, bit4 `rx_ovr`, bit5 `tx_ovf`, bit6 `rx_ferr`, bit7 0. Write: write-1-to-clear on bits 0, 4, 5, 6; other bits ignored.
- BASE+2 CTRL read/write: bit0 `rxie`, bit1 `txie`; other bits read 0.
- Reads have no side effects; software clears `rx_rdy` via STATUS.
- `pin_intr` = (`rxie` & `rx_rdy`) | (`txie` & `tx_empty`), registered.
- TX FSM: IDLE -> START (tx=0) -> DATA (8 bits, LSB first) -> STOP (tx=1) -> IDLE; each state bit lasts CLK_DIV cycles. FIFO pops on IDLE->START. Back-to-back bytes leave no idle gap.
- RX FSM: `uart_rx` passes a 2-flop synchroniser. IDLE: falling edge -> START, wait CLK_DIV/2; line high there -> IDLE (glitch rejected). Else DATA: sample every CLK_DIV, 8 bits LSB first. STOP: sample; if high, load holding register, set `rx_rdy`, and set `rx_ovr` if `rx_rdy` was already 1 (new byte overwrites). If low, byte discarded and `rx_ferr` set. Then IDLE.
- Simultaneous clear of `rx_rdy` and new-byte completion: the new byte wins, `rx_rdy` stays 1.

## Timing
- Reset values: `pin_pi`=8'h00, `pin_intr`=0, `uart_tx`=1, FIFO empty, both FSMs IDLE, all flags and CTRL 0.
- Reset mid-frame: `uart_tx` is 1 on the cycle after reset; the partial RX byte is lost.
- `pin_pi` is registered: it reflects `pin_pa` and register state one `clk` after the change, well inside one CPU cycle (4 clk).
- Write strobe edge at cycle N: register/FIFO updated at the N clock edge, visible on `pin_pi` at N+1 and on `pin_intr` at N+1.
- TX start: FIFO non-empty with FSM IDLE at cycle M, `uart_tx` falls at M+1. Frame length is 10×CLK_DIV.
- RX: `rx_rdy` rises 2 (sync) + 9.5×CLK_DIV (±1) cycles after the start-bit falling edge.

## Configuration
- `KR580_UART_RX_EN` defined: receiver, holding register and RX status/interrupt bits present as described.
- Not defined: no RX logic; `uart_rx` ignored; DATA read returns 8'h00; STATUS bits 0, 4, 6 read 0; `rxie` is stored but has no effect.

## Structure
- `kr580_uart_pkg`: register offsets (DATA=0, STATUS=1, CTRL=2), STATUS/CTRL bit indices, TX and RX FSM state enums.
- Sub-module `kr580_uart_fifo`: synchronous FIFO (push, pop, din, dout, empty, full), depth 2**FIFO_AW, count-based full/empty.
- Top holds the port decoder, strobe edge detect, TX/RX FSMs, baud counters and interrupt logic.

## Test plan
All with CLK_DIV=4.
- After reset: `pin_pi`=00, `uart_tx`=1, `pin_intr`=0. Read BASE+1 -> 8'h02.
- Write 8'hA5 to BASE+0 with `pin_pw` held 4 clk -> exactly one frame on `uart_tx`: 0,1,0,1,0,0,1,0,1,1, each bit 4 clk. STATUS bit1 returns to 1 afterwards.
- Push 17 bytes (FIFO_AW=4) while the first is transmitting -> 16 frames sent, STATUS bit5=1. Write 8'h20 to BASE+1 -> bit5=0.
- CTRL=01, drive frame 8'h3C on `uart_rx` -> `rx_rdy`=1, `pin_intr`=1, DATA read = 3C. Send 8'h7E before clearing -> DATA=7E, bit4=1. Write 8'h11 to STATUS -> `pin_intr`=0.
- RX frame with stop bit 0 -> `rx_rdy` unchanged, bit6=1. A 1-clk low glitch on `uart_rx` -> no flags set.
- Assert `reset` mid TX data bit -> `uart_tx`=1 next cycle, STATUS=8'h02; FIFO contents are not transmitted afterwards.
